bcd_seven_seg_scanner: RTL

- Sequential display stage directly downstream of the binary-to-BCD converter.
- Captures the three BCD digits (hundreds/tens/ones) on a load strobe.
- Applies new values only at frame boundaries, so no digit shows a half-updated value.
- Time-multiplexes the digits onto one shared 7-segment bus with one-hot digit enables, leading-zero blanking and invalid-digit flagging; drives the board's 3-digit common-segment display.

---
 rtl/bcd_seven_seg_scanner.sv | 85 ++++++++
 1 files changed

// File: rtl/bcd_seven_seg_scanner.sv
// bcd_seven_seg_scanner: captures BCD digits on load, applies them at frame boundaries and scans them onto one 7-seg bus (in: clk, rst_n, load, hundreds, tens, ones; out: seg, an, frame_done, bcd_err)
module bcd_seven_seg_scanner #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done,
  output logic       bcd_err
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {S_H, S_T, S_O} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0] sh_h, sh_t, sh_o, d_h, d_t, d_o, digit;
  logic pending, tick, boundary, blank;
  logic [6:0] seg_r, seg_nxt;
  logic [2:0] an_r, an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  always_comb begin
    tick = cnt == CW'(REFRESH_DIV - 1);
    state_nxt = state;
    if (tick) state_nxt = state == S_H ? S_T : state == S_T ? S_O : S_H;
    boundary = tick && state == S_O;
    digit = state == S_H ? d_h : state == S_T ? d_t : d_o;
    blank = BLANK_LZ && (state == S_H ? d_h == 4'd0 : state == S_T ? (d_h == 4'd0 && d_t == 4'd0) : 1'b0);
    seg_nxt = blank ? 7'h00 : decode(digit);
    an_nxt = blank ? 3'b000 : state == S_H ? 3'b100 : state == S_T ? 3'b010 : 3'b001;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_H;
    else state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      pending    <= 1'b0;
      {sh_h, sh_t, sh_o} <= '0;
      {d_h, d_t, d_o}    <= '0;
      bcd_err    <= 1'b0;
      frame_done <= 1'b0;
      seg_r      <= '0;
      an_r       <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      // copy sees the shadow as it stood before this edge; a same-cycle load stays pending
      if (boundary && pending) begin
        {d_h, d_t, d_o} <= {sh_h, sh_t, sh_o};
        bcd_err <= sh_h > 4'd9 || sh_t > 4'd9 || sh_o > 4'd9;
      end
      if (load) {sh_h, sh_t, sh_o} <= {hundreds, tens, ones};
      pending    <= load | (pending & ~boundary);
      frame_done <= boundary;
      seg_r      <= seg_nxt;
      an_r       <= an_nxt;
    end

  assign seg = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign an  = an_r ^ {3{AN_ACTIVE_LOW}};
endmodule
